// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer.
package btb_pkg;

  localparam int unsigned MODE_BIMODAL = 0;
  localparam int unsigned MODE_GSHARE  = 1;
  localparam int unsigned PC_W         = 32;

  // Counter value right after allocating on a taken branch.
  function automatic logic [31:0] cnt_weak_taken(input int unsigned cnt_bits);
    return 32'(1) << (cnt_bits - 1);
  endfunction

  // Counter value after reset; a 1-bit counter starts at not-taken.
  function automatic logic [31:0] cnt_weak_not_taken(input int unsigned cnt_bits);
    return (cnt_bits == 1) ? 32'(0) : ((32'(1) << (cnt_bits - 1)) - 32'(1));
  endfunction

  // Word-aligned table index, pc[idx_bits+1:2].
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_bits);
    return (pc >> 2) & ((32'(1) << idx_bits) - 32'(1));
  endfunction

  // Tag bits directly above the index field.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_bits,
                                         input int unsigned tag_bits);
    return (pc >> (idx_bits + 2)) & ((32'(1) << tag_bits) - 32'(1));
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter_upd.sv
// Next value of a saturating up/down direction counter.
module sat_counter_upd
  import btb_pkg::*;
#(
  parameter int unsigned CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cur,
  input  logic                taken,
  output logic [CNT_BITS-1:0] nxt
);

  // Step toward the outcome, holding at either end.
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != '1) nxt = cur + CNT_BITS'(1);
    end else begin
      if (cur != '0) nxt = cur - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped tagged branch target buffer with saturating direction
// counters and optional gshare indexing.
module btb_predictor
  import btb_pkg::*;
#(
  parameter  int unsigned ENTRIES   = 64,
  parameter  int unsigned TAG_BITS  = 8,
  parameter  int unsigned CNT_BITS  = 2,
  parameter  int unsigned MODE      = 0,
  parameter  int unsigned HIST_BITS = 6,
  localparam int unsigned HIST_W    = (MODE == MODE_GSHARE) ? HIST_BITS : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       lookup_pc,
  input  logic              lookup_branch,
  output logic              lookup_hit,
  output logic              predict_taken,
  output logic [31:0]       predict_target,
  output logic [HIST_W-1:0] lookup_hist,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  input  logic              flush
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  logic [ENTRIES-1:0]  valid_q;
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [HIST_W-1:0]   ghr_q;

  logic [IDX-1:0]      l_idx, u_idx, l_hmix, u_hmix;
  logic [TAG_BITS-1:0] l_tag, u_tag;
  logic                u_hit, upd_we;
  logic [CNT_BITS-1:0] cnt_nxt;

  // History contribution to the index; zero in bimodal mode.
  assign l_hmix = (MODE == MODE_GSHARE) ? IDX'(ghr_q)       : '0;
  assign u_hmix = (MODE == MODE_GSHARE) ? IDX'(update_hist) : '0;

  // Lookup path: same-cycle read of the current table contents.
  assign l_idx          = IDX'(pc_index(lookup_pc, IDX)) ^ l_hmix;
  assign l_tag          = TAG_BITS'(pc_tag(lookup_pc, IDX, TAG_BITS));
  assign lookup_hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign predict_taken  = lookup_branch && lookup_hit && cnt_q[l_idx][CNT_BITS-1];
  assign predict_target = lookup_hit ? target_q[l_idx] : 32'(0);
  assign lookup_hist    = ghr_q;

  // Update path: flush and reset both suppress table writes.
  assign u_idx  = IDX'(pc_index(update_pc, IDX)) ^ u_hmix;
  assign u_tag  = TAG_BITS'(pc_tag(update_pc, IDX, TAG_BITS));
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_we = update_en && !flush && reset;

  sat_counter_upd #(.CNT_BITS(CNT_BITS)) u_cnt_upd (
    .cur   (cnt_q[u_idx]),
    .taken (update_taken),
    .nxt   (cnt_nxt)
  );

  // Valid bits: flush clears all; taken miss allocates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_we && update_taken && !u_hit) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // Direction counters: train on hit, seed weakly taken on allocation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        cnt_q[i] <= CNT_BITS'(cnt_weak_not_taken(CNT_BITS));
      end
    end else if (upd_we) begin
      if (u_hit) cnt_q[u_idx] <= cnt_nxt;
      else if (update_taken) cnt_q[u_idx] <= CNT_BITS'(cnt_weak_taken(CNT_BITS));
    end
  end

  // Tags and targets are gated by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_we && update_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= update_target;
    end
  end

  // Global history shifts in resolved outcomes only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if ((MODE == MODE_GSHARE) && update_en) begin
      ghr_q <= HIST_W'({ghr_q, update_taken});
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench: bimodal table vectors plus gshare and reset sequences.
module tb_btb_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        lookup_branch;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        flush;
  logic [0:0]  uh0;
  logic [3:0]  uh1;

  logic        h0, t0, h1, t1;
  logic [31:0] tg0, tg1;
  logic [0:0]  lh0;
  logic [3:0]  lh1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        upd;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic        fl;
    logic [31:0] lpc;
    logic        lbr;
    logic        ehit;
    logic        etk;
    logic [31:0] etgt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  btb_predictor #(.ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(0), .HIST_BITS(4)) dut0 (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .lookup_branch(lookup_branch),
    .lookup_hit(h0), .predict_taken(t0), .predict_target(tg0), .lookup_hist(lh0),
    .update_en(update_en), .update_pc(update_pc), .update_hist(uh0),
    .update_taken(update_taken), .update_target(update_target), .flush(flush)
  );

  btb_predictor #(.ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(1), .HIST_BITS(4)) dut1 (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .lookup_branch(lookup_branch),
    .lookup_hit(h1), .predict_taken(t1), .predict_target(tg1), .lookup_hist(lh1),
    .update_en(update_en), .update_pc(update_pc), .update_hist(uh1),
    .update_taken(update_taken), .update_target(update_target), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_upd();
    update_en = 1'b0; update_pc = 32'h0; update_taken = 1'b0;
    update_target = 32'h0; flush = 1'b0; uh1 = 4'h0;
  endtask

  task automatic gs_update(input logic [31:0] pc, input logic [3:0] hist, input logic [31:0] tgt);
    update_en = 1'b1; update_pc = pc; update_taken = 1'b1; update_target = tgt; uh1 = hist;
    @(posedge clk); #1;
    idle_upd();
  endtask

  task automatic look1(input string nm, input logic [31:0] pc, input logic ehit,
                       input logic etk, input logic [31:0] etgt);
    lookup_pc = pc; lookup_branch = 1'b1;
    @(negedge clk);
    chk({nm, "_hit"}, 32'(h1), 32'(ehit));
    chk({nm, "_tk"},  32'(t1), 32'(etk));
    chk({nm, "_tgt"}, tg1, etgt);
  endtask

  initial begin
    // fields: upd upc utk utgt fl | lpc lbr | ehit etk etgt
    vecs[0]  = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[1]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[2]  = '{1'b1, 32'h40, 1'b0, 32'h999, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h100};
    vecs[3]  = '{1'b1, 32'h40, 1'b0, 32'h000, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[4]  = '{1'b1, 32'h40, 1'b0, 32'h000, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[5]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[6]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[7]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h100};
    vecs[8]  = '{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h100};
    vecs[9]  = '{1'b1, 32'h40, 1'b0, 32'h000, 1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 32'h100};
    vecs[10] = '{1'b1, 32'h40, 1'b0, 32'h000, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h100};
    vecs[11] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[12] = '{1'b1, 32'h40, 1'b1, 32'h140, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[13] = '{1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h140};
    vecs[14] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[15] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1, 32'h200};
    vecs[16] = '{1'b1, 32'h44, 1'b0, 32'h300, 1'b0, 32'h44, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[17] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h44, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[18] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h83, 1'b1, 1'b1, 1'b1, 32'h200};
    vecs[19] = '{1'b1, 32'h48, 1'b1, 32'h400, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h200};
    vecs[20] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[21] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h48, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[22] = '{1'b1, 32'h80, 1'b1, 32'h204, 1'b0, 32'h48, 1'b1, 1'b0, 1'b0, 32'h000};
    vecs[23] = '{1'b0, 32'h00, 1'b0, 32'h000, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1, 32'h204};

    reset = 1'b0; uh0 = 1'b0; idle_upd();
    lookup_pc = 32'h40; lookup_branch = 1'b1;

    // Outputs held at zero while in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hit",  32'(h0), 32'h0);
    chk("rst_tk",   32'(t0), 32'h0);
    chk("rst_tgt",  tg0, 32'h0);
    chk("rst_hist0", 32'(lh0), 32'h0);
    chk("rst_hist1", 32'(lh1), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Bimodal table-driven vectors: lookup checked before the edge that commits the update.
    for (int i = 0; i < NV; i++) begin
      update_en = vecs[i].upd; update_pc = vecs[i].upc; update_taken = vecs[i].utk;
      update_target = vecs[i].utgt; flush = vecs[i].fl;
      lookup_pc = vecs[i].lpc; lookup_branch = vecs[i].lbr;
      @(negedge clk);
      chk($sformatf("v%0d_hit", i), 32'(h0), 32'(vecs[i].ehit));
      chk($sformatf("v%0d_tk", i),  32'(t0), 32'(vecs[i].etk));
      chk($sformatf("v%0d_tgt", i), tg0, vecs[i].etgt);
      chk($sformatf("v%0d_hist", i), 32'(lh0), 32'h0);
      @(posedge clk); #1;
    end
    idle_upd();

    // Reset asserted mid-update: update discarded, table invalidated.
    update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_target = 32'h700;
    lookup_pc = 32'h80; lookup_branch = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("midrst_hit", 32'(h0), 32'h0);
    chk("midrst_tgt", tg0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; idle_upd();
    lookup_pc = 32'h40;
    @(negedge clk);
    chk("postrst_40_hit", 32'(h0), 32'h0);
    chk("postrst_40_tgt", tg0, 32'h0);
    lookup_pc = 32'h80;
    #1;
    chk("postrst_80_hit", 32'(h0), 32'h0);
    @(posedge clk); #1;

    // Gshare: history builds to 0111, last update allocates PC 0x44 at entry 1^7=6.
    chk("gs_hist0", 32'(lh1), 32'h0);
    gs_update(32'h80, 4'b0000, 32'h500);
    chk("gs_hist1", 32'(lh1), 32'h1);
    gs_update(32'h80, 4'b0001, 32'h500);
    chk("gs_hist2", 32'(lh1), 32'h3);
    gs_update(32'h44, 4'b0111, 32'h600);
    chk("gs_hist3", 32'(lh1), 32'h7);
    look1("gs_44", 32'h44, 1'b1, 1'b1, 32'h600);
    look1("gs_80", 32'h80, 1'b0, 1'b0, 32'h0);
    look1("gs_98", 32'h98, 1'b1, 1'b1, 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised successor to the fetch-stage branch target buffer; sits beside the PC register in Fetch, updated from Decode on branch resolution.
- Direct-mapped, tagged table of targets with N-bit saturating direction counters replacing the single "taken" bit.
- Optional gshare indexing via a global history register; table-wide flush port for context change.

Parameters:
- ENTRIES, 64, table depth; power of two, minimum 4.
- TAG_BITS, 8, PC tag bits stored per entry.
- CNT_BITS, 2, saturating counter width, 1 to 3.
- MODE, 0, 0 = PC-indexed (bimodal), 1 = gshare (PC index XOR history).
- HIST_BITS, 6, global history length; must be ≤ log2(ENTRIES); ignored when MODE=0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_pc  in  32  Fetch PC (PCF).
- lookup_branch  in  1  Fetch instruction is a branch (BranchF).
- lookup_hit  out  1  valid entry with tag match.
- predict_taken  out  1  predicted taken.
- predict_target  out  32  stored target; 0 on miss.
- lookup_hist  out  HIST_BITS  current history; Fetch pipes it to Decode alongside PC. Width is 1 when MODE=0.
- update_en  in  1  Decode-stage branch resolved this cycle (BranchD & ~StallD).
- update_pc  in  32  PC of the resolving branch (PCD).
- update_hist  in  HIST_BITS  history captured at that branch's lookup.
- update_taken  in  1  actual outcome (BranchTakenD).
- update_target  in  32  computed target (PCBranchD).
- flush  in  1  invalidate all entries.

Behaviour:
- Index and tag:
  - idx = pc[IDX+1:2], where IDX = log2(ENTRIES); when MODE=1, XOR the low HIST_BITS of idx with the history.
  - tag = pc[IDX+TAG_BITS+1:IDX+2]; pc[1:0] is ignored.
- Lookup is purely combinational, same cycle:
  - lookup_hit = valid[idx] & tag match.
  - predict_taken = lookup_branch & lookup_hit & counter MSB.
  - predict_target = target[idx] if hit, else 0.
- Lookup returns pre-update contents when an update to the same index occurs in the same cycle. There is no write-to-read bypass.
- Update (registered, one edge) when update_en=1, indexed with update_pc/update_hist:
  - Hit, taken: counter += 1, saturating at all-ones; target written.
  - Hit, not taken: counter -= 1, saturating at 0; target unchanged.
  - Miss, taken: allocate; valid=1, tag written, target written, counter = weakly taken (1 << (CNT_BITS-1)). Overwrites any aliasing entry.
  - Miss, not taken: no table change.
- History (MODE=1): when update_en=1, ghr <= {ghr[HIST_BITS-2:0], update_taken}. Shifting uses the resolved outcome only; there is no speculative history.
- Flush: all valid bits clear at the next edge; counters, tags and targets are untouched.
  - If flush and update_en coincide, flush wins and no allocation occurs.
- Reset (asynchronous, active-low):
  - All valid = 0, counters = weakly not-taken ((1 << (CNT_BITS-1)) - 1, or 0 when CNT_BITS=1), ghr = 0.
  - Outputs during and after reset: lookup_hit=0, predict_taken=0, predict_target=0, lookup_hist=0.
  - Reset asserted mid-update discards the update.
- Targets and tags need no reset; the valid bit gates them.
- CNT_BITS=1 degenerates to a last-outcome predictor with the same update rules.

Decomposition:
- Shared package btb_pkg:
  - MODE_BIMODAL / MODE_GSHARE constants.
  - Functions for counter init values (weak-taken, weak-not-taken).
  - Index/tag extraction helper functions.
- One sub-module, sat_counter_upd: combinational next-value for a CNT_BITS saturating counter (inputs cur, taken; output nxt). Instantiated once, on the update path.

Test Plan:
- Reset, then lookup PC 0x40 with branch=1 -> hit=0, taken=0, target=0x0.
- Update PC 0x40, taken, target 0x100 -> next cycle lookup 0x40: hit=1, taken=1, target=0x100, counter=2'b10.
- Two not-taken updates of 0x40 (CNT_BITS=2) -> counter 2'b00, taken=0, hit=1. Three more taken updates -> counter saturates at 2'b11; a fourth leaves it at 2'b11.
- Alias with ENTRIES=16: allocate 0x40 (idx 0, tag 1), then taken update of 0x80 (idx 0, tag 2), target 0x200 -> lookup 0x40 hit=0; lookup 0x80 target=0x200.
- Same-cycle update and lookup of 0x40 -> lookup shows the old value; the new value appears the next cycle. Flush coincident with a taken miss update -> all valid=0, no allocation.
- MODE=1, HIST_BITS=4: three taken updates -> lookup_hist=4'b0111. Lookup 0x44 indexes entry 1^7=6; an allocation made with update_hist=4'b0111 at PC 0x44 hits.
